// File: rtl/rst_btn_ctrl_if.sv
// Button front-end signal bundle: raw pad in, debounced events and the
// PLL/system reset request out. The slave side is the controller; the
// master side is whoever drives the pad and consumes the events.
interface rst_btn_ctrl_if;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_short;
    logic btn_long;
    logic rst_req;

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_short,
        output btn_long,
        output rst_req
    );

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_short,
        input  btn_long,
        input  rst_req
    );
endinterface

// File: rtl/rst_btn_ctrl_debounce.sv
// Synchroniser, debounce counter and press/release edge pulses for the raw
// button pad. The accept strobes are combinational and fire in the cycle
// before the registered level/pulses change, so a consumer can update its
// own registers on the same edge the new level appears.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 60000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_accept_press,
    output logic o_accept_release
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{BTN_ACTIVE_LOW}};

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_s;
    logic                   w_accept;

    // Shift the pad through the synchroniser; preset to the released level
    // so leaving reset never looks like a press edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= SYNC_IDLE;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
        end
    end

    assign w_s      = r_sync[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;
    assign w_accept = (w_s != r_level) && (r_cnt == CNT_LAST);

    // Count consecutive cycles of disagreement; any agreement restarts the
    // count, and a full window flips the level and emits one edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_accept & w_s;
            r_release <= w_accept & ~w_s;
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_level          = r_level;
    assign o_press          = r_press;
    assign o_release        = r_release;
    assign o_accept_press   = w_accept & w_s;
    assign o_accept_release = w_accept & ~w_s;
endmodule

// File: rtl/rst_btn_ctrl.sv
// User-button controller: classifies debounced presses as short or long and
// generates the PLL/system reset request, both as a power-on pulse and as a
// pulse on every long press so a held button restarts the clocking chain.
module rst_btn_ctrl #(
    parameter int SYNC_STAGES       = 2,
    parameter bit BTN_ACTIVE_LOW    = 1'b1,
    parameter int DEBOUNCE_CYCLES   = 60000,
    parameter int LONG_PRESS_CYCLES = 12000000,
    parameter int RST_PULSE_CYCLES  = 16,
    parameter bit LONG_RESET_EN     = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    rst_btn_ctrl_if.slave  btn_bus
);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    state_t        r_state;
    logic [HW-1:0] r_hold_cnt;
    logic          r_short;
    logic          r_long;
    logic [PW-1:0] r_pulse_cnt;
    logic          r_rst_req;

    logic w_level;
    logic w_press;
    logic w_release;
    logic w_accept_press;
    logic w_accept_release;
    logic w_long_hit;
    logic w_long_trig;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_btn            (btn_bus.btn_in),
        .o_level          (w_level),
        .o_press          (w_press),
        .o_release        (w_release),
        .o_accept_press   (w_accept_press),
        .o_accept_release (w_accept_release)
    );

    // A release arriving on the threshold edge wins, so it suppresses the
    // long event and its reset pulse.
    assign w_long_hit  = (r_state == HELD) && (r_hold_cnt == HOLD_LAST) && !w_accept_release;
    assign w_long_trig = w_long_hit & LONG_RESET_EN;

    // Press-classification FSM with the hold counter and registered
    // short/long pulses, updated on the same edge the debounced level moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_short <= 1'b0;
            r_long  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept_press) begin
                        r_state    <= HELD;
                        r_hold_cnt <= '0;
                    end
                end
                HELD: begin
                    if (w_accept_release) begin
                        r_short <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_long_hit) begin
                        r_long  <= 1'b1;
                        r_state <= LONG;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                    end
                end
                LONG: begin
                    if (w_accept_release) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Reset-request pulse: loaded at power-on and on each long press; a new
    // trigger reloads the counter so overlapping pulses merge with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_cnt <= PULSE_LOAD;
            r_rst_req   <= 1'b1;
        end else if (w_long_trig) begin
            r_pulse_cnt <= PULSE_LOAD;
            r_rst_req   <= 1'b1;
        end else if (r_pulse_cnt != '0) begin
            r_pulse_cnt <= r_pulse_cnt - PULSE_ONE;
            r_rst_req   <= (r_pulse_cnt != PULSE_ONE);
        end else begin
            r_rst_req <= 1'b0;
        end
    end

    assign btn_bus.btn_level   = w_level;
    assign btn_bus.btn_press   = w_press;
    assign btn_bus.btn_release = w_release;
    assign btn_bus.btn_short   = r_short;
    assign btn_bus.btn_long    = r_long;
    assign btn_bus.rst_req     = r_rst_req;
endmodule

// File: tb/tb_rst_btn_ctrl.sv
// Bench for the button controller: a table of press lengths around the
// debounce and long-press boundaries, plus hand sequences for power-on,
// bounce rejection and reset during a hold.
module tb_rst_btn_ctrl;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int LONGP = 20;
    localparam int RSTP  = 3;
    localparam int LAT   = SYNC + DEB;

    typedef struct {
        int low_len;
        int exp_press;
        int exp_short;
        int exp_long;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    int   press_cnt, rel_cnt, short_cnt, long_cnt, rst_cycles;
    int   press_step, rel_step, long_step;
    int   rst_at_long;

    vec_t vecs [6];

    rst_btn_ctrl_if bus ();

    rst_btn_ctrl #(
        .SYNC_STAGES       (SYNC),
        .BTN_ACTIVE_LOW    (1'b1),
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONGP),
        .RST_PULSE_CYCLES  (RSTP),
        .LONG_RESET_EN     (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_bus (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        press_cnt   = 0;
        rel_cnt     = 0;
        short_cnt   = 0;
        long_cnt    = 0;
        rst_cycles  = 0;
        press_step  = -1;
        rel_step    = -1;
        long_step   = -1;
        rst_at_long = 0;
    endtask

    // One clock: drive the pad, let a rising edge pass, sample at the falling edge
    task automatic stepCycle(input logic pad);
        bus.btn_in = pad;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        checkOutput("press_release_exclusive", int'(bus.btn_press & bus.btn_release), 0);
        if (bus.btn_press) begin
            press_cnt++;
            if (press_step < 0) press_step = cyc;
        end
        if (bus.btn_release) begin
            rel_cnt++;
            if (rel_step < 0) rel_step = cyc;
        end
        if (bus.btn_short) short_cnt++;
        if (bus.btn_long) begin
            long_cnt++;
            if (long_step < 0) long_step = cyc;
            if (bus.rst_req) rst_at_long = 1;
        end
        if (bus.rst_req) rst_cycles++;
    endtask

    task automatic applyStimulus(input logic pad, input int n);
        for (int i = 0; i < n; i++) stepCycle(pad);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_level"},   int'(bus.btn_level),   0);
        checkOutput({tag, "_press"},   int'(bus.btn_press),   0);
        checkOutput({tag, "_release"}, int'(bus.btn_release), 0);
        checkOutput({tag, "_short"},   int'(bus.btn_short),   0);
        checkOutput({tag, "_long"},    int'(bus.btn_long),    0);
        checkOutput({tag, "_rst_req"}, int'(bus.rst_req),     1);
    endtask

    initial begin
        int fall;
        int rise;
        int rel;

        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        bus.btn_in = 1'b1;
        clearMonitor();

        vecs[0] = '{low_len: 3,  exp_press: 0, exp_short: 0, exp_long: 0};
        vecs[1] = '{low_len: 4,  exp_press: 1, exp_short: 1, exp_long: 0};
        vecs[2] = '{low_len: 12, exp_press: 1, exp_short: 1, exp_long: 0};
        vecs[3] = '{low_len: 20, exp_press: 1, exp_short: 1, exp_long: 0};
        vecs[4] = '{low_len: 21, exp_press: 1, exp_short: 0, exp_long: 1};
        vecs[5] = '{low_len: 40, exp_press: 1, exp_short: 0, exp_long: 1};

        // Power-on: reset values, then a pulse ending on the RSTP-th edge
        repeat (3) @(negedge clk);
        checkResetValues("por");
        rst_n = 1'b1;
        rel = cyc + 1;
        applyStimulus(1'b1, 12);
        checkOutput("por_rst_cycles", rst_cycles, RSTP - 1);
        checkOutput("por_rst_low", int'(bus.rst_req), 0);
        checkOutput("por_no_press", press_cnt, 0);
        checkOutput("por_no_release", rel_cnt, 0);
        checkOutput("por_no_short", short_cnt, 0);
        checkOutput("por_no_long", long_cnt, 0);

        // Table: press lengths around the debounce and long thresholds
        for (int v = 0; v < 6; v++) begin
            $display("[TB] vector %0d: pad low for %0d cycles", v, vecs[v].low_len);
            clearMonitor();
            fall = cyc + 1;
            applyStimulus(1'b0, vecs[v].low_len);
            rise = cyc + 1;
            applyStimulus(1'b1, 16);
            checkOutput("vec_press_cnt", press_cnt, vecs[v].exp_press);
            checkOutput("vec_release_cnt", rel_cnt, vecs[v].exp_press);
            checkOutput("vec_short_cnt", short_cnt, vecs[v].exp_short);
            checkOutput("vec_long_cnt", long_cnt, vecs[v].exp_long);
            checkOutput("vec_rst_cycles", rst_cycles, vecs[v].exp_long * RSTP);
            checkOutput("vec_level_end", int'(bus.btn_level), 0);
            if (vecs[v].exp_press != 0) begin
                checkOutput("vec_press_latency", press_step - fall + 1, LAT);
                checkOutput("vec_release_latency", rel_step - rise + 1, LAT);
            end
            if (vecs[v].exp_long != 0) begin
                checkOutput("vec_long_delay", long_step - press_step, LONGP);
                checkOutput("vec_rst_with_long", rst_at_long, 1);
            end
        end

        // Bouncing pad: only the final settled fall produces a press
        clearMonitor();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2);
            applyStimulus(1'b1, 2);
        end
        checkOutput("bounce_no_press_yet", press_cnt, 0);
        fall = cyc + 1;
        applyStimulus(1'b0, 10);
        checkOutput("bounce_press_cnt", press_cnt, 1);
        checkOutput("bounce_press_latency", press_step - fall + 1, LAT);
        checkOutput("bounce_level_held", int'(bus.btn_level), 1);
        applyStimulus(1'b1, 14);
        checkOutput("bounce_release_cnt", rel_cnt, 1);
        checkOutput("bounce_short_cnt", short_cnt, 1);

        // Reset asserted mid-hold, button still held through and after it
        clearMonitor();
        applyStimulus(1'b0, 15);
        checkOutput("midrst_press_before", press_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        @(negedge clk);
        clearMonitor();
        rst_n = 1'b1;
        rel = cyc + 1;
        applyStimulus(1'b0, 40);
        checkOutput("midrst_press_cnt", press_cnt, 1);
        checkOutput("midrst_press_latency", press_step - rel + 1, LAT);
        checkOutput("midrst_long_cnt", long_cnt, 1);
        checkOutput("midrst_long_delay", long_step - press_step, LONGP);
        checkOutput("midrst_rst_with_long", rst_at_long, 1);
        checkOutput("midrst_rst_cycles", rst_cycles, (RSTP - 1) + RSTP);
        applyStimulus(1'b1, 14);
        checkOutput("midrst_release_cnt", rel_cnt, 1);
        checkOutput("midrst_short_cnt", short_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
